ex_mem_store_stage: RTL and testbench
=====================================

// Module: ex_mem_store_stage
// PURPOSE
//   EX/MEM pipeline register for the five-stage core, with store-path logic. Consumes the 2-bit
//   store forwarding flag and picks the store data from ID/EX rs2, the EX/MEM result or the
//   MEM/WB writeback value. Aligns that data and builds byte enables for SB/SH/SW/SD.
//   Supports stall (hold) and flush (bubble). Feeds the data memory and the MEM/WB register.
// PARAMETERS
//   REG_WIDTH  64  datapath width in bits; 32 or 64 only
//   REG_COUNT  32  architectural register count; RA = $clog2(REG_COUNT)
// PORTS
//   clk               in   1            single clock, rising edge
//   rst               in   1            synchronous, active-high reset
//   stall             in   1            hold every EX/MEM register this cycle
//   flush             in   1            load a bubble this cycle
//   ID_EX_valid       in   1            EX-stage instruction is valid
//   ID_EX_reg_write   in   1            instruction writes rd
//   ID_EX_mem_read    in   1            load
//   ID_EX_mem_write   in   1            store
//   ID_EX_funct3      in   3            000 SB, 001 SH, 010 SW, 011 SD
//   ID_EX_rd_addr     in   RA           destination register
//   ID_EX_rs2_data    in   REG_WIDTH    rs2 value read in ID
//   alu_result        in   REG_WIDTH    ALU result / effective address
//   fwd_flag          in   2            01 EX/MEM, 10 MEM/WB, 00 or 11 no forward
//   MEM_WB_wb_data    in   REG_WIDTH    value being written back this cycle
//   EX_MEM_valid      out  1            registered valid
//   EX_MEM_reg_write  out  1            registered control
//   EX_MEM_mem_read   out  1            registered control
//   EX_MEM_mem_write  out  1            registered control; 0 when misaligned
//   EX_MEM_rd_addr    out  RA           registered rd
//   EX_MEM_alu_result out  REG_WIDTH    registered ALU result / address
//   EX_MEM_store_data out  REG_WIDTH    lane-shifted store data
//   EX_MEM_byte_en    out  REG_WIDTH/8  byte-lane write enables
//   EX_MEM_misaligned out  1            store was misaligned or illegal; dropped
//   store_count       out  32           committed-store counter
// BEHAVIOUR
//   - Reset: all outputs are 0, including store_count. Priority: rst > flush > stall > normal capture.
//   - Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
//   - Store source (combinational, before the register):
//       01 -> current EX_MEM_alu_result; 10 -> MEM_WB_wb_data; 00 or 11 -> ID_EX_rs2_data.
//   - Load-use hazards are resolved by the hazard unit's stall. This block does not detect them.
//   - Size: funct3 values 000/001/010/011 select 1/2/4/8 bytes.
//       SD with REG_WIDTH=32 and funct3[2]=1 are illegal.
//   - off = alu_result[$clog2(REG_WIDTH/8)-1:0].
//       Misaligned when off is not a multiple of the size.
//   - Legal store:
//       byte_en    = ((1<<size)-1) << off
//       store_data = (src masked to size*8 bits) << (8*off)
//       Shifted-out bits are discarded.
//   - Misaligned or illegal store: EX_MEM_mem_write=0, byte_en=0, store_data=0,
//     EX_MEM_misaligned=1. Every other field is captured normally.
//   - Non-store, or ID_EX_valid=0: byte_en=0, store_data=0, misaligned=0.
//   - Invalid input (ID_EX_valid=0): reg_write, mem_read and mem_write are captured as 0.
//   - Flush: loads a bubble. All controls, valid, byte_en and misaligned go to 0.
//     Data and rd fields go to 0.
//   - Stall without flush: every register, including store_count, holds its value.
//   - store_count increments by 1, wrapping from 2^32-1 to 0, on each edge that captures
//     a legal store. A capture requires no rst, flush or stall; a legal store is
//     ID_EX_valid & ID_EX_mem_write & not misaligned.
//   - rst or flush asserted mid-pipeline take effect at the next edge. No partial state remains.
// TESTING
//   1. rst=1 for 2 cycles -> every output is 0. Release and send a bubble -> outputs stay 0.
//   2. SW, W=64, alu_result=0x104, rs2=0xDEADBEEF_12345678, flag=00
//      -> byte_en=0xF0, store_data=0x12345678_00000000, mem_write=1, store_count=1.
//   3. SB at addr 0x3, flag=01, with prior EX_MEM_alu_result=0xAB
//      -> byte_en=0x08, store_data=0x00000000_AB000000.
//      Same store with flag=10 and MEM_WB_wb_data=0xCD -> store_data byte3=0xCD.
//   4. SH at addr 0x5 -> mem_write=0, byte_en=0, misaligned=1, store_count unchanged.
//      SD at addr 0x8 -> byte_en=0xFF.
//   5. stall=1 for 3 cycles while a new store is at the input -> outputs and store_count hold.
//      stall and flush together -> bubble, valid=0.
//   6. store_count preloaded near wrap (force 0xFFFFFFFF), one legal store -> 0x00000000.
//      rst during a stall clears everything.

Source files
------------

// File: rtl/ex_mem_store_stage.sv
// EX/MEM pipeline register with store-path logic: forwarding mux, size/alignment check,
// byte-lane shifting of store data and byte-enable generation, plus a committed-store counter.
module ex_mem_store_stage #(
  parameter int unsigned REG_WIDTH = 64,
  parameter int unsigned REG_COUNT = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           flush,
  input  logic                           ID_EX_valid,
  input  logic                           ID_EX_reg_write,
  input  logic                           ID_EX_mem_read,
  input  logic                           ID_EX_mem_write,
  input  logic [2:0]                     ID_EX_funct3,
  input  logic [$clog2(REG_COUNT)-1:0]   ID_EX_rd_addr,
  input  logic [REG_WIDTH-1:0]           ID_EX_rs2_data,
  input  logic [REG_WIDTH-1:0]           alu_result,
  input  logic [1:0]                     fwd_flag,
  input  logic [REG_WIDTH-1:0]           MEM_WB_wb_data,
  output logic                           EX_MEM_valid,
  output logic                           EX_MEM_reg_write,
  output logic                           EX_MEM_mem_read,
  output logic                           EX_MEM_mem_write,
  output logic [$clog2(REG_COUNT)-1:0]   EX_MEM_rd_addr,
  output logic [REG_WIDTH-1:0]           EX_MEM_alu_result,
  output logic [REG_WIDTH-1:0]           EX_MEM_store_data,
  output logic [REG_WIDTH/8-1:0]         EX_MEM_byte_en,
  output logic                           EX_MEM_misaligned,
  output logic [31:0]                    store_count
);

  localparam int unsigned RA = $clog2(REG_COUNT);
  localparam int unsigned NB = REG_WIDTH / 8;
  localparam int unsigned OW = $clog2(NB);

  logic [REG_WIDTH-1:0] src_data;
  logic [OW-1:0]        off;
  logic [7:0]           be_base;
  logic [NB-1:0]        be_size;
  logic [REG_WIDTH-1:0] data_mask;
  logic                 illegal;
  logic                 misalign;
  logic                 is_store;
  logic                 bad_store;
  logic                 good_store;
  logic [NB-1:0]        be_next;
  logic [REG_WIDTH-1:0] sd_next;

  // Store source: forward from the EX/MEM register, the writeback bus, or the ID/EX read.
  always_comb begin
    src_data = ID_EX_rs2_data;
    unique case (fwd_flag)
      2'b01:   src_data = EX_MEM_alu_result;
      2'b10:   src_data = MEM_WB_wb_data;
      default: src_data = ID_EX_rs2_data;
    endcase
  end

  assign off = alu_result[OW-1:0];

  // Unshifted lane mask for the access size; 8-byte stores are illegal on a 32-bit datapath.
  always_comb begin
    be_base  = 8'h00;
    illegal  = ID_EX_funct3[2];
    misalign = 1'b0;
    unique case (ID_EX_funct3[1:0])
      2'b00: be_base = 8'h01;
      2'b01: begin
        be_base  = 8'h03;
        misalign = off[0];
      end
      2'b10: begin
        be_base  = 8'h0F;
        misalign = |off[1:0];
      end
      default: begin
        be_base  = 8'hFF;
        if (REG_WIDTH == 32) illegal = 1'b1;
        else                 misalign = |off;
      end
    endcase
  end

  assign be_size = NB'(be_base);

  always_comb begin
    data_mask = '0;
    for (int i = 0; i < NB; i++) begin
      data_mask[8*i +: 8] = {8{be_size[i]}};
    end
  end

  assign is_store   = ID_EX_valid & ID_EX_mem_write;
  assign bad_store  = is_store & (illegal | misalign);
  assign good_store = is_store & ~(illegal | misalign);

  always_comb begin
    be_next = '0;
    sd_next = '0;
    if (good_store) begin
      be_next = be_size << off;
      sd_next = (src_data & data_mask) << {off, 3'b000};
    end
  end

  // Pipeline register: reset beats flush beats stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      EX_MEM_valid      <= 1'b0;
      EX_MEM_reg_write  <= 1'b0;
      EX_MEM_mem_read   <= 1'b0;
      EX_MEM_mem_write  <= 1'b0;
      EX_MEM_rd_addr    <= '0;
      EX_MEM_alu_result <= '0;
      EX_MEM_store_data <= '0;
      EX_MEM_byte_en    <= '0;
      EX_MEM_misaligned <= 1'b0;
      store_count       <= '0;
    end else if (flush) begin
      EX_MEM_valid      <= 1'b0;
      EX_MEM_reg_write  <= 1'b0;
      EX_MEM_mem_read   <= 1'b0;
      EX_MEM_mem_write  <= 1'b0;
      EX_MEM_rd_addr    <= '0;
      EX_MEM_alu_result <= '0;
      EX_MEM_store_data <= '0;
      EX_MEM_byte_en    <= '0;
      EX_MEM_misaligned <= 1'b0;
    end else if (!stall) begin
      EX_MEM_valid      <= ID_EX_valid;
      EX_MEM_reg_write  <= ID_EX_valid & ID_EX_reg_write;
      EX_MEM_mem_read   <= ID_EX_valid & ID_EX_mem_read;
      EX_MEM_mem_write  <= good_store;
      EX_MEM_rd_addr    <= RA'(ID_EX_rd_addr);
      EX_MEM_alu_result <= alu_result;
      EX_MEM_store_data <= sd_next;
      EX_MEM_byte_en    <= be_next;
      EX_MEM_misaligned <= bad_store;
      if (good_store) store_count <= store_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_ex_mem_store_stage.sv
// Scoreboard bench for ex_mem_store_stage: a byte-loop reference model predicts each capture,
// expectations are queued when stimulus is driven and compared after the clock edge.
module tb_ex_mem_store_stage;

  localparam int unsigned W  = 64;
  localparam int unsigned NB = W / 8;
  localparam int unsigned RA = 5;

  logic          clk = 1'b0;
  logic          rst, stall, flush;
  logic          id_valid, id_rw, id_mr, id_mw;
  logic [2:0]    id_f3;
  logic [RA-1:0] id_rd;
  logic [W-1:0]  id_rs2, alu, wb;
  logic [1:0]    flag;

  logic          o_valid, o_rw, o_mr, o_mw, o_mis;
  logic [RA-1:0] o_rd;
  logic [W-1:0]  o_alu, o_sd;
  logic [NB-1:0] o_be;
  logic [31:0]   o_cnt;

  typedef struct packed {
    logic          valid;
    logic          rw;
    logic          mr;
    logic          mw;
    logic [RA-1:0] rd;
    logic [W-1:0]  alu;
    logic [W-1:0]  sd;
    logic [NB-1:0] be;
    logic          mis;
    logic [31:0]   cnt;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  ex_mem_store_stage #(.REG_WIDTH(W), .REG_COUNT(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ID_EX_valid(id_valid), .ID_EX_reg_write(id_rw), .ID_EX_mem_read(id_mr),
    .ID_EX_mem_write(id_mw), .ID_EX_funct3(id_f3), .ID_EX_rd_addr(id_rd),
    .ID_EX_rs2_data(id_rs2), .alu_result(alu), .fwd_flag(flag), .MEM_WB_wb_data(wb),
    .EX_MEM_valid(o_valid), .EX_MEM_reg_write(o_rw), .EX_MEM_mem_read(o_mr),
    .EX_MEM_mem_write(o_mw), .EX_MEM_rd_addr(o_rd), .EX_MEM_alu_result(o_alu),
    .EX_MEM_store_data(o_sd), .EX_MEM_byte_en(o_be), .EX_MEM_misaligned(o_mis),
    .store_count(o_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: place the source bytes one lane at a time starting at the offset.
  function automatic exp_t model_next(input exp_t cur);
    exp_t         n;
    logic [W-1:0] src;
    int           size, off;
    logic         bad, st;
    n = cur;
    if (rst) begin
      n = '0;
    end else if (flush) begin
      n = '0;
      n.cnt = cur.cnt;
    end else if (!stall) begin
      src  = (flag == 2'b01) ? cur.alu : (flag == 2'b10) ? wb : id_rs2;
      size = 1 << id_f3[1:0];
      off  = int'(alu % NB);
      bad  = id_f3[2] || (size > NB) || ((off % size) != 0);
      st   = id_valid && id_mw;
      n.valid = id_valid;
      n.rw    = id_valid && id_rw;
      n.mr    = id_valid && id_mr;
      n.mw    = st && !bad;
      n.rd    = id_rd;
      n.alu   = alu;
      n.mis   = st && bad;
      n.be    = '0;
      n.sd    = '0;
      if (st && !bad) begin
        for (int b = 0; b < NB; b++) begin
          if (b >= off && b < off + size) begin
            n.be[b] = 1'b1;
            n.sd[8*b +: 8] = src[8*(b-off) +: 8];
          end
        end
        n.cnt = cur.cnt + 32'd1;
      end
    end
    return n;
  endfunction

  task automatic cycle();
    exp_t e;
    m = model_next(m);
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("valid",     64'(o_valid), 64'(e.valid));
    chk("reg_write", 64'(o_rw),    64'(e.rw));
    chk("mem_read",  64'(o_mr),    64'(e.mr));
    chk("mem_write", 64'(o_mw),    64'(e.mw));
    chk("rd_addr",   64'(o_rd),    64'(e.rd));
    chk("alu",       o_alu,        e.alu);
    chk("store_data", o_sd,        e.sd);
    chk("byte_en",   64'(o_be),    64'(e.be));
    chk("misaligned", 64'(o_mis),  64'(e.mis));
    chk("store_count", 64'(o_cnt), 64'(e.cnt));
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                       input logic [2:0] f3, input logic [RA-1:0] rd, input logic [W-1:0] rs2,
                       input logic [W-1:0] a, input logic [1:0] fl, input logic [W-1:0] w);
    id_valid = v; id_rw = rw; id_mr = mr; id_mw = mw; id_f3 = f3; id_rd = rd;
    id_rs2 = rs2; alu = a; flag = fl; wb = w;
  endtask

  task automatic store(input logic [2:0] f3, input logic [W-1:0] rs2, input logic [W-1:0] a,
                       input logic [1:0] fl, input logic [W-1:0] w);
    drive(1'b1, 1'b0, 1'b0, 1'b1, f3, 5'd0, rs2, a, fl, w);
  endtask

  initial begin
    m = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, '0, '0, 2'b00, '0);

    // Reset for two cycles, then a bubble.
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // SW at 0x104 from rs2.
    store(3'b010, 64'hDEADBEEF_12345678, 64'h104, 2'b00, '0);
    cycle();
    chk("sw_be_const", 64'(o_be), 64'hF0);
    chk("sw_sd_const", o_sd, 64'h12345678_00000000);
    chk("sw_cnt_const", 64'(o_cnt), 64'd1);

    // ALU op leaves 0xAB in EX/MEM, then SB at 0x3 forwarding it.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'd7, '0, 64'hAB, 2'b00, '0);
    cycle();
    store(3'b000, 64'h11, 64'h3, 2'b01, 64'hCD);
    cycle();
    chk("sb_fwd_be", 64'(o_be), 64'h08);
    chk("sb_fwd_sd", o_sd, 64'h00000000_AB000000);
    store(3'b000, 64'h11, 64'h3, 2'b10, 64'hCD);
    cycle();
    chk("sb_wb_sd", o_sd, 64'h00000000_CD000000);

    // Misaligned SH, aligned SD, illegal funct3.
    store(3'b001, 64'h1234, 64'h5, 2'b00, '0);
    cycle();
    chk("sh_mis", 64'(o_mis), 64'd1);
    store(3'b011, 64'h01234567_89ABCDEF, 64'h8, 2'b00, '0);
    cycle();
    chk("sd_be_const", 64'(o_be), 64'hFF);
    store(3'b110, 64'h55, 64'h0, 2'b00, '0);
    cycle();

    // Stall three cycles with a new store pending, then stall+flush.
    store(3'b001, 64'hBEEF, 64'h6, 2'b11, '0);
    stall = 1'b1;
    repeat (3) cycle();
    flush = 1'b1;
    cycle();
    chk("flush_valid", 64'(o_valid), 64'd0);
    stall = 1'b0; flush = 1'b0;
    cycle();

    // Counter wrap from a preloaded value.
    @(negedge clk);
    force dut.store_count = 32'hFFFF_FFFF;
    #1;
    release dut.store_count;
    m.cnt = 32'hFFFF_FFFF;
    store(3'b010, 64'hCAFEF00D, 64'h20, 2'b00, '0);
    cycle();
    chk("wrap_cnt", 64'(o_cnt), 64'd0);
    store(3'b000, 64'h77, 64'h1, 2'b00, '0);
    cycle();

    // Random mix of ops with occasional stall/flush.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom_range(0, 4)), 5'($urandom), {$urandom, $urandom},
            64'($urandom_range(0, 255)), 2'($urandom), {$urandom, $urandom});
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cycle();
    end
    stall = 1'b0; flush = 1'b0;

    // Reset during a stall.
    store(3'b010, 64'h1, 64'h0, 2'b00, '0);
    cycle();
    stall = 1'b1; rst = 1'b1;
    cycle();
    chk("rst_stall_cnt", 64'(o_cnt), 64'd0);
    stall = 1'b0; rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
